// File: rtl/biquad_sym_zero_fir_nch.sv
// Symmetric zero-section FIR over NSAMP parallel samples per clock, with a
// double-buffered coefficient loader and a latency-matched bypass path.
module biquad_sym_zero_fir_nch #(
    parameter int unsigned NBITS   = 16,
    parameter int unsigned NFRAC   = 2,
    parameter int unsigned NSAMP   = 8,
    parameter int unsigned NTAP    = 3,
    parameter int unsigned CBITS   = 18,
    parameter int unsigned CFRAC   = 14,
    parameter int unsigned OUTBITS = 16,
    parameter int unsigned OUTFRAC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NBITS*NSAMP-1:0]   dat_i,
    input  logic                     bypass_i,
    input  logic [CBITS-1:0]         coeff_dat_i,
    input  logic                     coeff_wr_i,
    input  logic                     coeff_update_i,
    output logic [OUTBITS*NSAMP-1:0] dat_o,
    output logic [NSAMP-1:0]         sat_o,
    output logic [1:0]               coeff_state_o,
    output logic                     coeff_err_o
);
    localparam int unsigned H     = (NTAP - 1) / 2;
    localparam int unsigned NC    = H + 1;
    localparam int unsigned IW    = (H > 0) ? $clog2(H + 1) : 1;
    localparam int unsigned VW    = NBITS * NSAMP;
    localparam int unsigned PAW   = NBITS + 1;
    localparam int unsigned PW    = PAW + CBITS;
    localparam int unsigned AW    = PW + $clog2(NC) + 1;
    localparam int unsigned F_RSH = (NFRAC + CFRAC > OUTFRAC) ? NFRAC + CFRAC - OUTFRAC : 0;
    localparam int unsigned F_LSH = (OUTFRAC > NFRAC + CFRAC) ? OUTFRAC - NFRAC - CFRAC : 0;
    localparam int unsigned B_RSH = (NFRAC > OUTFRAC) ? NFRAC - OUTFRAC : 0;
    localparam int unsigned B_LSH = (OUTFRAC > NFRAC) ? OUTFRAC - NFRAC : 0;
    localparam int unsigned SW    = AW + F_LSH + B_LSH;
    localparam int unsigned CDLY  = 3;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_ARMED = 2'd2} state_e;
    typedef logic signed [CBITS-1:0] coef_t;
    typedef logic signed [NBITS-1:0] smp_t;

    localparam coef_t C_ONE = CBITS'(1 << CFRAC);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUTBITS+1){1'b0}}, {(OUTBITS-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUTBITS+1){1'b1}}, {(OUTBITS-1){1'b0}}};

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                err_q, err_d;
    coef_t               stg_q [NC], stg_d [NC];
    coef_t               act_q [NC], act_d [NC];
    coef_t               cpipe_q [CDLY][NC], cpipe_d [CDLY][NC];
    logic [VW-1:0]       in_q, in_d, mid_q, mid_d, old_q, old_d;
    logic [3:0]          byp_q, byp_d;
    smp_t                win [3*NSAMP];
    logic signed [PAW-1:0] pre_q [NSAMP][NC], pre_d [NSAMP][NC];
    logic signed [PW-1:0]  prod_q [NSAMP][NC], prod_d [NSAMP][NC];
    smp_t                cen_q [NSAMP], cen_d [NSAMP];
    logic [OUTBITS*NSAMP-1:0] dat_q, dat_d;
    logic [NSAMP-1:0]    sat_q, sat_d;
    logic signed [SW-1:0] acc_c, val_c;

    // Coefficient loader: update takes priority over a simultaneous write
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        stg_d   = stg_q;
        act_d   = act_q;
        if (coeff_update_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            if (state_q == ST_ARMED) begin
                act_d = stg_q;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
                for (int k = 0; k < NC; k++) stg_d[k] = '0;
            end
        end else if (coeff_wr_i) begin
            case (state_q)
                ST_IDLE: begin
                    stg_d[0] = coeff_dat_i;
                    idx_d    = (H == 0) ? '0 : IW'(1);
                    state_d  = (H == 0) ? ST_ARMED : ST_LOAD;
                end
                ST_LOAD: begin
                    stg_d[idx_q] = coeff_dat_i;
                    if (idx_q == IW'(H)) begin
                        state_d = ST_ARMED;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Window, pre-add and multiply stages; coefficient set travels with the centre vector
    always_comb begin
        in_d  = dat_i;
        mid_d = in_q;
        old_d = mid_q;
        byp_d = {byp_q[2:0], bypass_i};
        cpipe_d[0] = act_q;
        for (int d = 1; d < CDLY; d++) cpipe_d[d] = cpipe_q[d-1];
        for (int i = 0; i < NSAMP; i++) begin
            win[i]           = $signed(old_q[NBITS*i +: NBITS]);
            win[NSAMP+i]     = $signed(mid_q[NBITS*i +: NBITS]);
            win[2*NSAMP+i]   = $signed(in_q[NBITS*i +: NBITS]);
        end
        for (int i = 0; i < NSAMP; i++) begin
            pre_d[i][0] = PAW'(win[NSAMP+i]);
            for (int k = 1; k < NC; k++)
                pre_d[i][k] = PAW'(win[NSAMP+i-k]) + PAW'(win[NSAMP+i+k]);
            for (int k = 0; k < NC; k++)
                prod_d[i][k] = PW'(pre_q[i][k]) * PW'(cpipe_q[CDLY-1][k]);
            cen_d[i] = NBITS'(pre_q[i][0]);
        end
    end

    // Sum, floor to output format, select bypass, saturate
    always_comb begin
        dat_d = '0;
        sat_d = '0;
        acc_c = '0;
        val_c = '0;
        for (int i = 0; i < NSAMP; i++) begin
            acc_c = '0;
            for (int k = 0; k < NC; k++) acc_c = acc_c + SW'(prod_q[i][k]);
            if (byp_q[3]) val_c = (SW'(cen_q[i]) <<< B_LSH) >>> B_RSH;
            else          val_c = (acc_c <<< F_LSH) >>> F_RSH;
            if (val_c > SAT_MAX) begin
                dat_d[OUTBITS*i +: OUTBITS] = SAT_MAX[OUTBITS-1:0];
                sat_d[i] = 1'b1;
            end else if (val_c < SAT_MIN) begin
                dat_d[OUTBITS*i +: OUTBITS] = SAT_MIN[OUTBITS-1:0];
                sat_d[i] = 1'b1;
            end else begin
                dat_d[OUTBITS*i +: OUTBITS] = val_c[OUTBITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NC; k++) begin
                stg_q[k] <= '0;
                act_q[k] <= (k == 0) ? C_ONE : '0;
                for (int d = 0; d < CDLY; d++) cpipe_q[d][k] <= (k == 0) ? C_ONE : '0;
            end
            in_q  <= '0;
            mid_q <= '0;
            old_q <= '0;
            byp_q <= '0;
            for (int i = 0; i < NSAMP; i++) begin
                cen_q[i] <= '0;
                for (int k = 0; k < NC; k++) begin
                    pre_q[i][k]  <= '0;
                    prod_q[i][k] <= '0;
                end
            end
            dat_q <= '0;
            sat_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            stg_q   <= stg_d;
            act_q   <= act_d;
            cpipe_q <= cpipe_d;
            in_q    <= in_d;
            mid_q   <= mid_d;
            old_q   <= old_d;
            byp_q   <= byp_d;
            pre_q   <= pre_d;
            prod_q  <= prod_d;
            cen_q   <= cen_d;
            dat_q   <= dat_d;
            sat_q   <= sat_d;
        end
    end

    assign dat_o         = dat_q;
    assign sat_o         = sat_q;
    assign coeff_state_o = state_q;
    assign coeff_err_o   = err_q;

endmodule

// File: tb/tb_biquad_sym_zero_fir_nch.sv
// Directed table-driven bench for biquad_sym_zero_fir_nch (default parameters).
module tb_biquad_sym_zero_fir_nch;
    localparam int unsigned NB = 16;
    localparam int unsigned NS = 8;
    localparam int unsigned CB = 18;
    localparam int unsigned OB = 16;
    localparam int unsigned VW = NB * NS;
    localparam int unsigned OW = OB * NS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] dat_i;
    logic          bypass_i;
    logic [CB-1:0] coeff_dat_i;
    logic          coeff_wr_i;
    logic          coeff_update_i;
    logic [OW-1:0] dat_o;
    logic [NS-1:0] sat_o;
    logic [1:0]    coeff_state_o;
    logic          coeff_err_o;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [VW-1:0] din;
        logic          byp;
        logic          upd;
        logic [OW-1:0] dexp;
        logic [NS-1:0] sexp;
    } vec_t;

    vec_t tbl [16];
    int   ntbl;

    biquad_sym_zero_fir_nch #(
        .NBITS(16), .NFRAC(2), .NSAMP(8), .NTAP(3),
        .CBITS(18), .CFRAC(14), .OUTBITS(16), .OUTFRAC(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dat_i          (dat_i),
        .bypass_i       (bypass_i),
        .coeff_dat_i    (coeff_dat_i),
        .coeff_wr_i     (coeff_wr_i),
        .coeff_update_i (coeff_update_i),
        .dat_o          (dat_o),
        .sat_o          (sat_o),
        .coeff_state_o  (coeff_state_o),
        .coeff_err_o    (coeff_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] put(input logic [OW-1:0] v, input int idx, input int val);
        logic [OW-1:0] r;
        r = v;
        r[OB*idx +: OB] = OB'(val);
        return r;
    endfunction

    function automatic logic [OW-1:0] all_s(input int val);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) r = put(r, i, val);
        return r;
    endfunction

    task automatic check(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic st(input string nm, input int s, input logic e);
        check({nm, ".state"}, OW'(coeff_state_o), OW'(s));
        check({nm, ".err"}, OW'(coeff_err_o), OW'(e));
    endtask

    task automatic clr();
        ntbl = 0;
    endtask

    task automatic add(input logic [VW-1:0] din, input logic byp, input logic upd,
                       input logic [OW-1:0] dexp, input logic [NS-1:0] sexp);
        tbl[ntbl] = '{din, byp, upd, dexp, sexp};
        ntbl++;
    endtask

    // Vector j is driven before edge j; its output is stable before edge j+5
    task automatic run_table(input string nm);
        for (int c = 0; c < ntbl + 5; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                check($sformatf("%s[%0d].dat", nm, c - 5), dat_o, tbl[c-5].dexp);
                check($sformatf("%s[%0d].sat", nm, c - 5), OW'(sat_o), OW'(tbl[c-5].sexp));
            end
            if (c < ntbl) begin
                dat_i          = tbl[c].din;
                bypass_i       = tbl[c].byp;
                coeff_update_i = tbl[c].upd;
            end else begin
                dat_i          = '0;
                bypass_i       = 1'b0;
                coeff_update_i = 1'b0;
            end
        end
    endtask

    task automatic pulse(input logic wr, input logic upd, input int val);
        @(negedge clk);
        coeff_wr_i     = wr;
        coeff_update_i = upd;
        coeff_dat_i    = CB'(val);
        @(negedge clk);
        coeff_wr_i     = 1'b0;
        coeff_update_i = 1'b0;
    endtask

    task automatic imp4_table(input string nm, input int c_cen, input int c_side);
        clr();
        add(put('0, 4, 400), 1'b0, 1'b0,
            put(put(put('0, 4, c_cen), 3, c_side), 5, c_side), '0);
        run_table(nm);
    endtask

    initial begin
        logic [OW-1:0] v;
        rst_n = 1'b0;
        dat_i = all_s(1234);
        bypass_i = 1'b0;
        coeff_dat_i = '0;
        coeff_wr_i = 1'b0;
        coeff_update_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.dat", dat_o, '0);
        check("rst.sat", OW'(sat_o), '0);
        st("rst", 0, 1'b0);
        dat_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // identity set: output is the input delayed 4 clocks
        clr();
        for (int j = 0; j < 5; j++) begin
            v = '0;
            for (int i = 0; i < NS; i++) v = put(v, i, (j * 8 + i) * 100 - 1500);
            add(v, 1'b0, 1'b0, v, '0);
        end
        run_table("ramp");
        st("ramp", 0, 1'b0);

        pulse(1'b1, 1'b0, 8192);  st("ld_a1", 1, 1'b0);
        pulse(1'b1, 1'b0, 4096);  st("ld_a2", 2, 1'b0);
        pulse(1'b0, 1'b1, 0);     st("ld_acommit", 0, 1'b0);

        // impulses across vector boundaries and floor of negative half values
        clr();
        add('0, 1'b0, 1'b0, '0, '0);
        add(put('0, 7, 400), 1'b0, 1'b0, put(put('0, 7, 200), 6, 100), '0);
        add('0, 1'b0, 1'b0, put('0, 0, 100), '0);
        add(put('0, 3, -1), 1'b0, 1'b0, put(put(put('0, 2, -1), 3, -1), 4, -1), '0);
        add('0, 1'b0, 1'b0, put('0, 7, -100), '0);
        add(put('0, 0, -400), 1'b0, 1'b0, put(put('0, 0, -200), 1, -100), '0);
        run_table("impulse");

        // bypass on a single vector between filtered neighbours
        clr();
        add('0, 1'b0, 1'b0, put('0, 7, 100), '0);
        add(all_s(400), 1'b0, 1'b0, put(put(all_s(400), 0, 300), 7, 500), '0);
        add(all_s(800), 1'b1, 1'b0, all_s(800), '0);
        add(all_s(400), 1'b0, 1'b0, put(put(all_s(400), 0, 500), 7, 300), '0);
        add('0, 1'b0, 1'b0, put('0, 0, 100), '0);
        run_table("bypass");

        pulse(1'b1, 1'b0, 49152);
        pulse(1'b1, 1'b0, 0);
        pulse(1'b0, 1'b1, 0);     st("ld_sat", 0, 1'b0);
        clr();
        v = '0;
        v = put(v, 0, 20000); v = put(v, 1, -20000); v = put(v, 2, 1000);  v = put(v, 3, 0);
        v = put(v, 4, -1000); v = put(v, 5, 10922);  v = put(v, 6, 10923); v = put(v, 7, -10923);
        add(v, 1'b0, 1'b0,
            put(put(put(put(put(put(put(put('0, 0, 32767), 1, -32768), 2, 3000), 3, 0),
                4, -3000), 5, 32766), 6, 32767), 7, -32768),
            8'b1100_0011);
        add(all_s(-5461), 1'b0, 1'b0, all_s(-16383), '0);
        run_table("sat");

        // atomic commit mid-stream: set A passes alternating input, set B nulls it
        pulse(1'b1, 1'b0, 16384);
        pulse(1'b1, 1'b0, 0);
        pulse(1'b0, 1'b1, 0);     st("ld_setA", 0, 1'b0);
        pulse(1'b1, 1'b0, 8192);  st("stg_b1", 1, 1'b0);
        pulse(1'b1, 1'b0, 4096);  st("stg_b2", 2, 1'b0);
        v = '0;
        for (int i = 0; i < NS; i++) v = put(v, i, (i % 2 == 0) ? 100 : -100);
        clr();
        add(v, 1'b0, 1'b0, v, '0);
        add(v, 1'b0, 1'b0, v, '0);
        add(v, 1'b0, 1'b1, v, '0);
        add(v, 1'b0, 1'b0, '0, '0);
        add(v, 1'b0, 1'b0, '0, '0);
        add(v, 1'b0, 1'b0, put('0, 7, -25), '0);
        run_table("atomic");
        st("atomic_done", 0, 1'b0);

        // extra write in ARMED is ignored and flagged; commit clears the flag
        pulse(1'b1, 1'b0, 16384); st("w3_1", 1, 1'b0);
        pulse(1'b1, 1'b0, 0);     st("w3_2", 2, 1'b0);
        pulse(1'b1, 1'b0, 8192);  st("w3_3", 2, 1'b1);
        pulse(1'b0, 1'b1, 0);     st("w3_commit", 0, 1'b0);
        imp4_table("w3_set", 400, 0);

        pulse(1'b0, 1'b1, 0);     st("upd_idle", 0, 1'b1);
        pulse(1'b1, 1'b0, 8192);  st("part_1", 1, 1'b1);
        pulse(1'b0, 1'b1, 0);     st("upd_load", 0, 1'b1);
        pulse(1'b1, 1'b0, 8192);  st("reload_1", 1, 1'b1);
        pulse(1'b1, 1'b0, 4096);  st("reload_2", 2, 1'b1);
        pulse(1'b1, 1'b1, 999);   st("wr_upd", 0, 1'b0);
        imp4_table("wr_upd_set", 200, 100);

        // async reset in LOAD restores identity set and clears the loader
        pulse(1'b0, 1'b1, 0);     st("pre_rst_err", 0, 1'b1);
        pulse(1'b1, 1'b0, 16384); st("pre_rst_load", 1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 st("rst_async", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        imp4_table("rst_identity", 400, 0);
        pulse(1'b1, 1'b0, 8192);  st("post_rst_1", 1, 1'b0);
        pulse(1'b1, 1'b0, 4096);  st("post_rst_2", 2, 1'b0);
        pulse(1'b0, 1'b1, 0);     st("post_rst_commit", 0, 1'b0);
        imp4_table("post_rst_set", 200, 100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
